// File: rtl/multdiv_issue_if.sv
// Execute-stage to multiply/divide issue bundle, including the writeback port.
// slave: issue block side. master: pipeline/unit side.
interface multdiv_issue_if;
  logic        dx_valid;
  logic        dx_is_mult;
  logic        dx_is_div;
  logic [31:0] dx_opA;
  logic [31:0] dx_opB;
  logic [4:0]  dx_rd;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_exception;

  modport slave (
    input  dx_valid, dx_is_mult, dx_is_div,
    input  dx_opA, dx_opB, dx_rd, flush,
    input  md_result, md_exception, md_resultRDY,
    output md_opA, md_opB,
    output md_ctrl_MULT, md_ctrl_DIV, stall,
    output wb_valid, wb_data, wb_rd, wb_exception
  );

  modport master (
    output dx_valid, dx_is_mult, dx_is_div,
    output dx_opA, dx_opB, dx_rd, flush,
    output md_result, md_exception, md_resultRDY,
    input  md_opA, md_opB,
    input  md_ctrl_MULT, md_ctrl_DIV, stall,
    input  wb_valid, wb_data, wb_rd, wb_exception
  );
endinterface

// File: rtl/multdiv_issue.sv
// Issues mult/div ops to an iterative unit, stalls the pipe, returns writeback.
// Ports: clock, resetn (async active-low), bus (multdiv_issue_if.slave).
module multdiv_issue #(
  parameter int TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             resetn,
  multdiv_issue_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [5:0] LP_LAST = 6'(TIMEOUT - 1);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_mult;
  logic        r_div;
  logic [4:0]  r_rd;
  logic        r_wbv;
  logic [31:0] r_wbd;
  logic [4:0]  r_wbrd;
  logic        r_wbexc;

  logic w_req;
  logic w_issue;
  logic w_accept;

  // Both flags high is a malformed decode and is never issued.
  assign w_req    = bus.dx_valid
                  & (bus.dx_is_mult ^ bus.dx_is_div);
  assign w_issue  = (r_state == S_IDLE)
                  & w_req & ~bus.flush;
  // Ready at count 0 may be left over from the previous op.
  assign w_accept = (r_cnt != 6'd0)
                  & bus.md_resultRDY;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_mult  <= 1'b0;
      r_div   <= 1'b0;
      r_rd    <= '0;
      r_wbv   <= 1'b0;
      r_wbd   <= '0;
      r_wbrd  <= '0;
      r_wbexc <= 1'b0;
    end else begin
      r_mult <= 1'b0;
      r_div  <= 1'b0;
      r_wbv  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_opa   <= bus.dx_opA;
            r_opb   <= bus.dx_opB;
            r_rd    <= bus.dx_rd;
            r_mult  <= bus.dx_is_mult;
            r_div   <= bus.dx_is_div;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= bus.flush ? S_IDLE : S_BUSY;
        end
        S_BUSY: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
            // Ready takes priority over the timeout.
            if (w_accept) begin
              r_wbd   <= bus.md_result;
              r_wbexc <= bus.md_exception;
              r_wbrd  <= r_rd;
              r_wbv   <= 1'b1;
              r_state <= S_DONE;
            end else if (r_cnt == LP_LAST) begin
              r_wbd   <= '0;
              r_wbexc <= 1'b1;
              r_wbrd  <= r_rd;
              r_wbv   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.md_opA       = r_opa;
  assign bus.md_opB       = r_opb;
  assign bus.md_ctrl_MULT = r_mult;
  assign bus.md_ctrl_DIV  = r_div;
  assign bus.stall        = w_issue
                          | (r_state == S_START)
                          | (r_state == S_BUSY);
  // A squash in the done cycle kills the writeback.
  assign bus.wb_valid     = r_wbv & ~bus.flush;
  assign bus.wb_data      = r_wbd;
  assign bus.wb_rd        = r_wbrd;
  assign bus.wb_exception = r_wbexc;

endmodule

// File: doc/multdiv_issue.md
MULTDIV_ISSUE -- requirements
Module: multdiv_issue

Interface
REQ-001 Parameter TIMEOUT, default 40, is the maximum number of BUSY cycles allowed before the operation is aborted.
REQ-002 The block SHALL operate from one clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 dx_valid  in  1  execute-stage instruction valid.
REQ-006 dx_is_mult, dx_is_div  in  1 each  opcode decode flags.
REQ-007 dx_opA, dx_opB  in  32 each  source operands.
REQ-008 dx_rd  in  5  destination register.
REQ-009 flush  in  1  pipeline squash of the in-flight instruction.
REQ-010 md_result  in  32; md_exception  in  1; md_resultRDY  in  1  all driven by the multiply/divide unit.
REQ-011 md_opA, md_opB  out  32 each  registered operands to the multiply/divide unit.
REQ-012 md_ctrl_MULT, md_ctrl_DIV  out  1 each  one-cycle start pulses.
REQ-013 stall  out  1  freezes the fetch, decode and execute stages.
REQ-014 wb_valid  out  1; wb_data  out  32; wb_rd  out  5; wb_exception  out  1  writeback port.

Function
REQ-015 The FSM SHALL have the states IDLE, START, BUSY and DONE, plus a 6-bit BUSY cycle counter.
REQ-016 A request is dx_valid=1 with exactly one of dx_is_mult or dx_is_div high; a request with both flags high SHALL be ignored, with no stall and no issue.
REQ-017 IDLE + request + !flush: operands, rd and op type are latched, and the next state is START.
REQ-018 In IDLE, stall SHALL be asserted combinationally in the same cycle as the request.
REQ-019 START: exactly one of md_ctrl_MULT/md_ctrl_DIV SHALL be high for exactly this cycle; counter is cleared to 0; next state is BUSY.
REQ-020 stall SHALL be 1 throughout START and BUSY.
REQ-021 md_opA and md_opB SHALL be held stable from START until the next issue.
REQ-022 BUSY: the counter increments each cycle.
REQ-023 md_resultRDY SHALL be ignored while counter==0, because a stale ready flag from the previous operation can still be high then.
REQ-024 BUSY, counter>=1 and md_resultRDY=1: md_result→wb_data, md_exception→wb_exception and latched rd→wb_rd are registered; next state is DONE.
REQ-025 BUSY with counter==TIMEOUT-1 and no accepted ready: wb_data=0, wb_exception=1; next state is DONE.
REQ-026 If ready and timeout occur in the same cycle, ready SHALL win.
REQ-027 DONE: wb_valid=1 for exactly one cycle; stall=0, so the instruction leaves execute; next state is IDLE.
REQ-028 Back-to-back requests are allowed: the request seen in the IDLE cycle after DONE SHALL issue normally.
REQ-029 flush in START or BUSY: next state is IDLE, with no wb_valid.
REQ-030 The multiply/divide unit is not stopped on flush; the next start pulse restarts it.
REQ-031 flush in DONE SHALL suppress wb_valid (forced to 0), and the next state is IDLE.
REQ-032 flush in IDLE SHALL block issue of that cycle's request.
REQ-033 Minimum latency: request in cycle 0, pulse in cycle 1, ready accepted in cycle 3, wb_valid in cycle 4.
REQ-034 All wb_* outputs SHALL hold their values outside DONE; wb_valid is the only qualifier.

Reset
REQ-035 On resetn=0 the FSM SHALL go to IDLE asynchronously.
REQ-036 While in reset, the counter and all registered outputs SHALL be 0: md_opA, md_opB, md_ctrl_*, wb_*.
REQ-037 On reset, stall SHALL be 0 unless a request is present in the first post-reset cycle.
REQ-038 Reset asserted mid-operation SHALL discard the operation, with no wb_valid.

Verification
REQ-039 Multiply: dx_opA=7, dx_opB=6, rd=3, multdiv ready at counter=16 with result 42 → one MULT pulse; stall for 19 cycles; wb_valid with wb_data=42, wb_rd=3, wb_exception=0.
REQ-040 Divide by zero: dx_opB=0, multdiv returns exception=1, result 0 → one DIV pulse; wb_exception=1, wb_data=0.
REQ-041 Stale ready: md_resultRDY held at 1 from START → not accepted at counter 0; accepted at counter 1; wb_valid 4 cycles after the request.
REQ-042 Timeout: TIMEOUT=40, ready never asserted → wb_valid at BUSY cycle 40 with wb_exception=1, wb_data=0; stall drops in that cycle.
REQ-043 Flush at BUSY counter 5 → IDLE, no wb_valid; the next request issues a fresh pulse and completes correctly.
REQ-044 Reset at BUSY counter 10 → all outputs 0 immediately; no wb_valid after release; dx_is_mult=dx_is_div=1 afterwards → no stall, no pulse.
